// File: rtl/current_source_ctrl.sv
// Closed-loop oscillator current-source controller: times the counter window, evaluates the
// frozen edge count against TARGET with a deadband and steps a saturating DAC code.
module current_source_ctrl #(
    parameter int CODE_W        = 6,
    parameter int CODE_INIT     = 32,
    parameter int WINDOW_CYCLES = 64,
    parameter int SETTLE_CYCLES = 4,
    parameter int DEADBAND      = 2,
    parameter int LOCK_COUNT    = 4
) (
    input  logic              CLK,
    input  logic              internal_rst_n,
    input  logic              EN,
    input  logic [7:0]        TARGET,
    input  logic [7:0]        COUNTER,
    output logic              COUNT_DONE,
    output logic [CODE_W-1:0] ISRC_CODE,
    output logic              MEAS_VALID,
    output logic [7:0]        MEAS_COUNT,
    output logic              LOCKED,
    output logic              SAT_HI,
    output logic              SAT_LO
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WINDOW = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_EVAL   = 2'd3;

    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int LOCK_W  = $clog2(LOCK_COUNT + 1);

    localparam logic [TMR_W-1:0]  WIN_LAST    = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_FULL   = LOCK_W'(LOCK_COUNT);
    localparam logic [CODE_W-1:0] CODE_MAX    = {CODE_W{1'b1}};
    localparam logic signed [9:0] DB_S        = 10'(DEADBAND);

    logic [1:0]        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              count_done_q, count_done_d;
    logic              meas_valid_q, meas_valid_d;
    logic [7:0]        meas_count_q, meas_count_d;
    logic              locked_q, locked_d;
    logic              sat_hi_q, sat_hi_d;
    logic              sat_lo_q, sat_lo_d;

    // Signed error over 10 bits cannot wrap, so the band edges clamp naturally at 0 and 255.
    logic signed [9:0] err;
    assign err = $signed({2'b00, COUNTER}) - $signed({2'b00, TARGET});

    function automatic logic [CODE_W-1:0] step_code(input logic [CODE_W-1:0] code,
                                                     input logic up);
        if (up)
            return (code == CODE_MAX) ? code : code + 1'b1;
        else
            return (code == '0) ? code : code - 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        lock_d       = lock_q;
        code_d       = code_q;
        meas_valid_d = 1'b0;
        meas_count_d = meas_count_q;
        locked_d     = locked_q;
        sat_hi_d     = sat_hi_q;
        sat_lo_d     = sat_lo_q;

        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    state_d = S_WINDOW;
                    timer_d = '0;
                end
            end
            S_WINDOW, S_HOLD: begin
                if (!EN) begin
                    state_d  = S_IDLE;
                    timer_d  = '0;
                    lock_d   = '0;
                    locked_d = 1'b0;
                end else if (timer_q == ((state_q == S_WINDOW) ? WIN_LAST : SETTLE_LAST)) begin
                    state_d = (state_q == S_WINDOW) ? S_HOLD : S_EVAL;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d      = EN ? S_WINDOW : S_IDLE;
                timer_d      = '0;
                meas_valid_d = 1'b1;
                meas_count_d = COUNTER;
                sat_hi_d     = 1'b0;
                sat_lo_d     = 1'b0;
                if (err < -DB_S) begin
                    code_d   = step_code(code_q, 1'b1);
                    sat_hi_d = (code_q == CODE_MAX);
                    lock_d   = '0;
                    locked_d = 1'b0;
                end else if (err > DB_S) begin
                    code_d   = step_code(code_q, 1'b0);
                    sat_lo_d = (code_q == '0);
                    lock_d   = '0;
                    locked_d = 1'b0;
                end else begin
                    if (lock_q != LOCK_FULL)
                        lock_d = lock_q + 1'b1;
                    locked_d = (lock_q >= LOCK_FULL - 1'b1);
                end
            end
        endcase

        count_done_d = (state_d != S_WINDOW);
    end

    always_ff @(posedge CLK or negedge internal_rst_n) begin
        if (!internal_rst_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            lock_q       <= '0;
            code_q       <= CODE_W'(CODE_INIT);
            count_done_q <= 1'b1;
            meas_valid_q <= 1'b0;
            meas_count_q <= '0;
            locked_q     <= 1'b0;
            sat_hi_q     <= 1'b0;
            sat_lo_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lock_q       <= lock_d;
            code_q       <= code_d;
            count_done_q <= count_done_d;
            meas_valid_q <= meas_valid_d;
            meas_count_q <= meas_count_d;
            locked_q     <= locked_d;
            sat_hi_q     <= sat_hi_d;
            sat_lo_q     <= sat_lo_d;
        end
    end

    assign COUNT_DONE = count_done_q;
    assign ISRC_CODE  = code_q;
    assign MEAS_VALID = meas_valid_q;
    assign MEAS_COUNT = meas_count_q;
    assign LOCKED     = locked_q;
    assign SAT_HI     = sat_hi_q;
    assign SAT_LO     = sat_lo_q;

endmodule
